// File: rtl/moore_seq_det.sv
// Moore serial pattern detector, KMP-style transition table built from LEN/PATTERN/OVERLAP.
// Define MOORE_SEQ_DET_COUNT_EN to add the saturating detection counter and its count port.
module moore_seq_det #(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = LEN'(3'b101),
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             I,
    output logic             det
`ifdef MOORE_SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    localparam int SW        = $clog2(LEN + 1);
    localparam int NUM_CODES = 1 << SW;

    typedef logic [SW-1:0] state_t;

    localparam state_t S0    = '0;
    localparam state_t S_LEN = state_t'(LEN);

    if (LEN < 2 || LEN > 16 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
        $error("moore_seq_det: LEN must be 2..16 and CNT_W 1..32");
    end

    // Longest j such that the last j bits of (first k pattern bits, then b) equal the first j pattern bits.
    function automatic int match_after(input int k, input logic b);
        int   res;
        int   idx;
        logic ok;
        logic sb;
        res = 0;
        for (int j = 1; j <= LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    idx = k + 1 - j + t;
                    sb  = (idx < k) ? PATTERN[LEN-1-idx] : b;
                    if (sb != PATTERN[LEN-1-t]) ok = 1'b0;
                end
                if (ok) res = j;
            end
        end
        return res;
    endfunction

    function automatic int border_len();
        int   res;
        logic ok;
        res = 0;
        for (int j = 1; j < LEN; j++) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
                if (PATTERN[LEN-1-t] != PATTERN[j-1-t]) ok = 1'b0;
            end
            if (ok) res = j;
        end
        return res;
    endfunction

    function automatic int next_code(input int c, input logic b);
        int res;
        if (c < LEN) begin
            res = match_after(c, b);
        end else if (c == LEN) begin
            if (OVERLAP != 0) res = match_after(border_len(), b);
            else              res = (b == PATTERN[LEN-1]) ? 1 : 0;
        end else begin
            res = 0;
        end
        return res;
    endfunction

    // Constant next-state table for every code, including unreachable ones (which map to S0).
    state_t nxt0_tab   [NUM_CODES];
    state_t nxt1_tab   [NUM_CODES];
    logic   code_valid [NUM_CODES];

    for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_tab
        localparam state_t N0 = state_t'(next_code(gi, 1'b0));
        localparam state_t N1 = state_t'(next_code(gi, 1'b1));
        assign nxt0_tab[gi]   = N0;
        assign nxt1_tab[gi]   = N1;
        assign code_valid[gi] = (gi <= LEN) ? 1'b1 : 1'b0;
    end

    state_t state_reg;
    state_t state_next;

    always_comb begin
        state_next = I ? nxt1_tab[state_reg] : nxt0_tab[state_reg];
    end

`ifdef MOORE_SEQ_DET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] count_reg;
    assign count = count_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S0;
            det       <= 1'b0;
`ifdef MOORE_SEQ_DET_COUNT_EN
            count_reg <= '0;
`endif
        end else if (!code_valid[state_reg]) begin
            // Recovery from a corrupted code does not wait for en.
            state_reg <= S0;
            det       <= 1'b0;
        end else if (en) begin
            state_reg <= state_next;
            det       <= (state_next == S_LEN);
`ifdef MOORE_SEQ_DET_COUNT_EN
            if (state_next == S_LEN && count_reg != CNT_MAX)
                count_reg <= count_reg + CNT_W'(1);
`endif
        end
    end

endmodule
